sram_port_controller: RTL and testbench
=======================================

SRAM_PORT_CONTROLLER -- requirements
Module: sram_port_controller

Interface
REQ-001 Parameters SHALL be: N 640 pixels per line; M 480 lines; ADDR_WIDTH 20 SRAM word-address width; DATA_WIDTH 16 SRAM word width.
REQ-002 One clock; reset is asynchronous and active-low. Ports SHALL be:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-low reset.
- i_WE_n  in  1  write window request, active low.
- i_OE_n  in  1  read mode request, active low.
- i_addr_inc  in  1  VGA active-region pixel strobe.
- i_wr_valid  in  1  write word offered.
- i_wr_data  in  DATA_WIDTH  write word.
- o_wr_ready  out  1  write word accepted when high with i_wr_valid.
- i_dq_in  in  DATA_WIDTH  SRAM DQ input path.
- o_dq_out  out  DATA_WIDTH  SRAM DQ output path.
- o_dq_oe  out  1  DQ driver enable; tristate is done at top level.
- o_sram_addr  out  ADDR_WIDTH  SRAM address.
- o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_ub_n, o_sram_lb_n  out  1 each  SRAM strobes, active low.
- o_rd_data  out  DATA_WIDTH  read word.
- o_rd_valid  out  1  one-cycle qualifier for o_rd_data.
- o_frame_done  out  1  one-cycle pulse after the last frame word is written.

Function
REQ-003 The FSM SHALL have states IDLE, WRITE, WR_STROBE, TURN and READ; all outputs except o_wr_ready SHALL be registered.
REQ-004 From IDLE:
- i_WE_n=0 SHALL go to WRITE.
- Otherwise i_OE_n=0 SHALL go to READ.
- Write SHALL win when both requests are low.
- Entering WRITE or READ SHALL clear the address to 0.
REQ-005 In WRITE:
- o_wr_ready=1, o_dq_oe=1, o_sram_oe_n=1, o_sram_we_n=1.
- On i_wr_valid&&o_wr_ready, i_wr_data SHALL be latched to o_dq_out and the FSM SHALL go to WR_STROBE.
REQ-006 In WR_STROBE:
- o_sram_we_n=0 for exactly one cycle, with address and data held stable.
- The FSM SHALL then increment the address and return to WRITE.
- Maximum throughput is 1 word per 2 cycles.
REQ-007 A strobe at address N*M-1 SHALL pulse o_frame_done for one cycle, reset the address to 0 and go to TURN.
REQ-008 If i_WE_n rises in WRITE, the FSM SHALL go to TURN. If it rises in WR_STROBE, the strobe SHALL complete first; a write SHALL never be truncated.
REQ-009 TURN SHALL last one cycle with o_dq_oe=0, o_sram_we_n=1, o_sram_oe_n=1, then go to IDLE.
REQ-010 In READ: o_dq_oe=0, o_sram_oe_n=0, o_sram_we_n=1.
REQ-011 In READ, on each cycle with i_addr_inc=1:
- i_dq_in SHALL be registered to o_rd_data.
- o_rd_valid=1 SHALL be asserted the next cycle (latency 1).
- The address SHALL increment.
REQ-012 In READ, the address SHALL wrap from N*M-1 to 0 without leaving READ.
REQ-013 In READ, i_OE_n=1 or i_WE_n=0 SHALL go to TURN. A pending o_rd_valid SHALL still be emitted.
REQ-014 o_sram_ce_n, o_sram_ub_n and o_sram_lb_n SHALL be 1 in IDLE and 0 in all other states.
REQ-015 N*M SHALL fit in ADDR_WIDTH, checked at elaboration. The address counter SHALL be ADDR_WIDTH bits and compare against N*M-1 cast to ADDR_WIDTH.
REQ-016 o_wr_ready SHALL be 0 in every state except WRITE.

Reset
REQ-017 On i_rst=0, the FSM SHALL be IDLE and the address 0.
REQ-018 On i_rst=0, outputs SHALL be:
- o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_ub_n, o_sram_lb_n = 1.
- o_dq_oe, o_rd_valid, o_frame_done = 0.
- o_dq_out, o_rd_data = 0.
REQ-019 Reset asserted during WR_STROBE SHALL force o_sram_we_n=1 immediately, asynchronously.

Structure
REQ-020 The state enum and the default N/M/ADDR_WIDTH/DATA_WIDTH constants SHALL live in package vga_sram_pkg.
REQ-021 The address counter with wrap-at-N*M SHALL be a sub-module named sram_addr_counter, with inputs clear and inc and outputs addr and last.

Verification
REQ-022 The bench SHALL run with N=4, M=2.
REQ-023 Scenario 1: drop i_WE_n, stream words 0x0001..0x0008 with i_wr_valid held high. Required response: eight one-cycle we_n pulses at addresses 0..7; o_frame_done pulses once after address 7; TURN seen, then IDLE.
REQ-024 Scenario 2: drop i_OE_n after scenario 1, pulse i_addr_inc 10 times with the SRAM model returning mem[addr]. Required response: o_rd_data = 0x0001..0x0008, 0x0001, 0x0002, each with o_rd_valid exactly one cycle after its strobe.
REQ-025 Scenario 3: i_WE_n=0 and i_OE_n=0 together from IDLE. Required response: WRITE is entered and o_sram_oe_n stays 1.
REQ-026 Scenario 4: raise i_WE_n in the cycle the FSM enters WR_STROBE at address 2. Required response: the strobe completes, address becomes 3, then TURN, and no further we_n pulse.
REQ-027 Scenario 5: assert i_rst mid-WR_STROBE. Required response: o_sram_we_n=1 and o_dq_oe=0 in the same cycle; the address reads 0 after release.
REQ-028 Scenario 6: write-to-read switch. Required response: o_dq_oe=0 for at least one cycle before o_sram_oe_n falls; o_dq_oe=1 never coincides with o_sram_oe_n=0.

Source files
------------

// File: rtl/vga_sram_pkg.sv
// Shared definitions for the VGA frame-buffer SRAM port controller.
//   state_e      : controller FSM states
//   *_DEF        : default frame geometry and SRAM bus widths
package vga_sram_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    WR_STROBE = 3'd2,
    TURN      = 3'd3,
    READ      = 3'd4
  } state_e;

  localparam int N_DEF          = 640;
  localparam int M_DEF          = 480;
  localparam int ADDR_WIDTH_DEF = 20;
  localparam int DATA_WIDTH_DEF = 16;

endpackage

// File: rtl/sram_addr_counter.sv
// Frame address counter for the SRAM port controller.
// Counts 0 .. N*M-1 and wraps back to 0.
//   i_clk, i_rst : clock, asynchronous active-low reset
//   clear        : synchronous return to address 0 (wins over inc)
//   inc          : advance by one word, wrapping after the last frame word
//   addr         : current word address (registered)
//   last         : addr is the final word of the frame
module sram_addr_counter
  import vga_sram_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int M          = M_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  clear,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam longint unsigned FRAME_WORDS = longint'(N) * longint'(M);
  localparam longint unsigned ADDR_SPACE  = 64'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N * M - 1);

  // Refuse to build a counter that cannot reach every frame word.
  if (FRAME_WORDS > ADDR_SPACE || FRAME_WORDS == 0) begin : g_frame_size_chk
    $error("sram_addr_counter: N*M does not fit in ADDR_WIDTH bits");
  end

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  assign last = (addr_q == LAST_ADDR);
  assign addr = addr_q;

  always_comb begin
    addr_d = addr_q;
    if (clear) begin
      addr_d = '0;
    end else if (inc) begin
      addr_d = last ? '0 : addr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/sram_port_controller.sv
// Single-port asynchronous SRAM controller for a VGA frame buffer.
// A writer streams one frame of words in (valid/ready), a VGA scanner
// reads them back one word per active pixel strobe.
//   i_clk, i_rst            : clock, asynchronous active-low reset
//   i_WE_n / i_OE_n         : write-window / read-mode requests (active low)
//   i_addr_inc              : read strobe from the VGA active region
//   i_wr_valid, i_wr_data   : write word offered; o_wr_ready accepts it
//   i_dq_in / o_dq_out      : SRAM DQ input / output path
//   o_dq_oe                 : DQ driver enable (tristate lives above)
//   o_sram_addr, o_sram_*_n : SRAM address and active-low strobes
//   o_rd_data, o_rd_valid   : read word and its one-cycle qualifier
//   o_frame_done            : one-cycle pulse after the final frame word
// Every output except o_wr_ready is a flop, so the SRAM pins never glitch.
module sram_port_controller
  import vga_sram_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int M          = M_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_WE_n,
  input  logic                  i_OE_n,
  input  logic                  i_addr_inc,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_dq_in,
  output logic [DATA_WIDTH-1:0] o_dq_out,
  output logic                  o_dq_oe,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_we_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_ub_n,
  output logic                  o_sram_lb_n,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_frame_done
);

  state_e state_q, state_d;

  logic addr_clear, addr_step, addr_last;
  logic wr_fire, rd_strobe;

  logic                  we_n_q, we_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  ce_n_q, ce_n_d;
  logic                  dq_oe_q, dq_oe_d;
  logic [DATA_WIDTH-1:0] dq_out_q, dq_out_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  frame_done_q, frame_done_d;

  // Ready is the only combinational output: it must reflect the current
  // state so that a word offered in WRITE is taken in that same cycle.
  assign o_wr_ready = (state_q == WRITE);
  assign wr_fire    = i_wr_valid && o_wr_ready;
  assign rd_strobe  = (state_q == READ) && i_addr_inc;

  sram_addr_counter #(
    .N          (N),
    .M          (M),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_counter (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .clear (addr_clear),
    .inc   (addr_step),
    .addr  (o_sram_addr),
    .last  (addr_last)
  );

  always_comb begin
    state_d    = state_q;
    addr_clear = 1'b0;
    addr_step  = 1'b0;
    case (state_q)
      IDLE: begin
        // Write has priority when both requests arrive together.
        if (!i_WE_n) begin
          state_d    = WRITE;
          addr_clear = 1'b1;
        end else if (!i_OE_n) begin
          state_d    = READ;
          addr_clear = 1'b1;
        end
      end
      WRITE: begin
        // An accepted word is always strobed, even if the window closes
        // in the same cycle; the window close is honoured afterwards.
        if (wr_fire) begin
          state_d = WR_STROBE;
        end else if (i_WE_n) begin
          state_d = TURN;
        end
      end
      WR_STROBE: begin
        addr_step = 1'b1;
        if (addr_last || i_WE_n) begin
          state_d = TURN;
        end else begin
          state_d = WRITE;
        end
      end
      TURN: begin
        state_d = IDLE;
      end
      READ: begin
        addr_step = i_addr_inc;
        if (i_OE_n || !i_WE_n) begin
          state_d = TURN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pin values are decoded from the next state so the registered outputs
  // line up with the state they belong to.
  always_comb begin
    we_n_d       = (state_d != WR_STROBE);
    oe_n_d       = (state_d != READ);
    ce_n_d       = (state_d == IDLE);
    dq_oe_d      = (state_d == WRITE) || (state_d == WR_STROBE);
    dq_out_d     = wr_fire ? i_wr_data : dq_out_q;
    rd_data_d    = rd_strobe ? i_dq_in : rd_data_q;
    rd_valid_d   = rd_strobe;
    frame_done_d = (state_q == WR_STROBE) && addr_last;
  end

  // Async reset parks the pins immediately, so a reset landing in the
  // middle of a write strobe releases WE and the DQ driver at once.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      ce_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
      dq_out_q     <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      ce_n_q       <= ce_n_d;
      dq_oe_q      <= dq_oe_d;
      dq_out_q     <= dq_out_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_sram_we_n  = we_n_q;
  assign o_sram_oe_n  = oe_n_q;
  assign o_sram_ce_n  = ce_n_q;
  assign o_sram_ub_n  = ce_n_q;
  assign o_sram_lb_n  = ce_n_q;
  assign o_dq_oe      = dq_oe_q;
  assign o_dq_out     = dq_out_q;
  assign o_rd_data    = rd_data_q;
  assign o_rd_valid   = rd_valid_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_sram_port_controller.sv
// Self-checking bench for sram_port_controller with a 4x2 frame.
// A behavioural SRAM sits on the pins; a reference memory and frame
// address model predict every strobe, read word and frame-done pulse.
module tb_sram_port_controller;

  localparam int N  = 4;
  localparam int M  = 2;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int NM = N * M;

  logic          i_clk = 1'b0;
  logic          rst_n;
  logic          i_WE_n, i_OE_n, i_addr_inc, i_wr_valid;
  logic [DW-1:0] i_wr_data;
  logic          o_wr_ready;
  logic [DW-1:0] i_dq_in, o_dq_out;
  logic          o_dq_oe;
  logic [AW-1:0] o_sram_addr;
  logic          o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_ub_n, o_sram_lb_n;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid, o_frame_done;

  sram_port_controller #(.N(N), .M(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk        (i_clk),
    .i_rst        (rst_n),
    .i_WE_n       (i_WE_n),
    .i_OE_n       (i_OE_n),
    .i_addr_inc   (i_addr_inc),
    .i_wr_valid   (i_wr_valid),
    .i_wr_data    (i_wr_data),
    .o_wr_ready   (o_wr_ready),
    .i_dq_in      (i_dq_in),
    .o_dq_out     (o_dq_out),
    .o_dq_oe      (o_dq_oe),
    .o_sram_addr  (o_sram_addr),
    .o_sram_we_n  (o_sram_we_n),
    .o_sram_oe_n  (o_sram_oe_n),
    .o_sram_ce_n  (o_sram_ce_n),
    .o_sram_ub_n  (o_sram_ub_n),
    .o_sram_lb_n  (o_sram_lb_n),
    .o_rd_data    (o_rd_data),
    .o_rd_valid   (o_rd_valid),
    .o_frame_done (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural SRAM on the pins.
  logic [DW-1:0] sram [NM];
  always @(posedge i_clk)
    if (rst_n && !o_sram_we_n && !o_sram_ce_n) sram[o_sram_addr[2:0]] <= o_dq_out;
  assign i_dq_in = !o_sram_oe_n ? sram[o_sram_addr[2:0]] : 16'hDEAD;

  // Reference model state.
  logic [DW-1:0] ref_mem [NM];
  int            ref_addr;
  int            exp_fd;
  logic [AW-1:0] exp_w_addr[$];
  logic [DW-1:0] exp_w_data[$];

  // Pin observations.
  logic [AW-1:0] mon_w_addr[$];
  logic [DW-1:0] mon_w_data[$];
  int  fd_cnt, overlap_cnt, oe_fall_bad, we_double;
  logic prev_we_low, prev_oe_n, prev_dq_oe;

  int n_checks, n_errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge i_clk) begin
    if (!rst_n) begin
      prev_we_low = 1'b0;
      prev_oe_n   = 1'b1;
      prev_dq_oe  = 1'b0;
    end else begin
      if (o_dq_oe && !o_sram_oe_n) overlap_cnt++;
      if (prev_oe_n && !o_sram_oe_n && prev_dq_oe) oe_fall_bad++;
      if (!o_sram_we_n) begin
        mon_w_addr.push_back(o_sram_addr);
        mon_w_data.push_back(o_dq_out);
        if (prev_we_low) we_double++;
      end
      if (o_frame_done) fd_cnt++;
      prev_we_low = !o_sram_we_n;
      prev_oe_n   = o_sram_oe_n;
      prev_dq_oe  = o_dq_oe;
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Opens the write window and offers n words; returns one step after the
  // edge that accepted the last one, i.e. while that word is being strobed.
  task automatic write_stream(input int n, input bit rnd);
    int  sent  = 0;
    int  guard = 0;
    bit  fire;
    ref_addr   = 0;
    i_WE_n     = 1'b0;
    i_wr_data  = rnd ? DW'($urandom) : DW'(1);
    i_wr_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (sent < n && guard < 2000) begin
      @(negedge i_clk);
      fire = o_wr_ready && i_wr_valid;
      if (fire) begin
        exp_w_addr.push_back(AW'(ref_addr));
        exp_w_data.push_back(i_wr_data);
        ref_mem[ref_addr] = i_wr_data;
        if (ref_addr == NM - 1) exp_fd++;
        ref_addr = (ref_addr + 1) % NM;
        sent++;
      end
      step();
      if (fire) i_wr_data = rnd ? DW'($urandom) : DW'(sent + 1);
      if (rnd) i_wr_valid = 1'($urandom_range(0, 1));
      guard++;
    end
    chk("wr_accept_count", sent, n);
  endtask

  // Enters READ and issues n pixel strobes; the request is dropped in the
  // same cycle as the final strobe so its valid must still appear.
  task automatic read_stream(input int n, input bit rnd);
    int            done  = 0;
    int            guard = 0;
    int            raddr = 0;
    bit            pend  = 1'b0;
    bit            inc;
    logic [DW-1:0] pexp  = '0;
    i_OE_n = 1'b0;
    while (o_sram_oe_n && guard < 20) begin
      step();
      guard++;
    end
    chk("rd_enter", o_sram_oe_n, 1'b0);
    chk("rd_no_drive", o_dq_oe, 1'b0);
    guard = 0;
    while ((done < n || pend) && guard < 500) begin
      chk("rd_valid", o_rd_valid, pend);
      if (pend) chk("rd_data", o_rd_data, pexp);
      inc = (done < n) && (!rnd || $urandom_range(0, 2) != 0);
      i_addr_inc = inc;
      if (inc) begin
        pexp  = ref_mem[raddr];
        raddr = (raddr + 1) % NM;
        done++;
        if (done == n) i_OE_n = 1'b1;
      end
      pend = inc;
      step();
      guard++;
    end
    chk("rd_strobe_count", done, n);
    i_addr_inc = 1'b0;
    i_OE_n     = 1'b1;
    step();
    step();
    chk("rd_back_idle", o_sram_ce_n, 1'b1);
  endtask

  // Final frame word is being strobed: expect the done pulse with TURN,
  // then close the window and see IDLE.
  task automatic end_frame();
    step();
    chk("frame_done_pulse", o_frame_done, 1'b1);
    chk("turn_dq_oe", o_dq_oe, 1'b0);
    chk("turn_ce_n", o_sram_ce_n, 1'b0);
    chk("turn_ready", o_wr_ready, 1'b0);
    chk("turn_addr_wrap", o_sram_addr, 0);
    i_WE_n     = 1'b1;
    i_wr_valid = 1'b0;
    step();
    chk("frame_done_once", o_frame_done, 1'b0);
    chk("idle_after_turn", o_sram_ce_n, 1'b1);
  endtask

  task automatic cmp_writes();
    int k;
    chk("wr_pulse_count", mon_w_addr.size(), exp_w_addr.size());
    k = (mon_w_addr.size() < exp_w_addr.size()) ? mon_w_addr.size() : exp_w_addr.size();
    for (int i = 0; i < k; i++) begin
      chk("wr_addr", mon_w_addr[i], exp_w_addr[i]);
      chk("wr_data", mon_w_data[i], exp_w_data[i]);
    end
    mon_w_addr.delete();
    mon_w_data.delete();
    exp_w_addr.delete();
    exp_w_data.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] saved;
    n_checks = 0; n_errors = 0;
    fd_cnt = 0; overlap_cnt = 0; oe_fall_bad = 0; we_double = 0;
    exp_fd = 0; ref_addr = 0;
    for (int i = 0; i < NM; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    rst_n = 1'b0;
    i_WE_n = 1'b1; i_OE_n = 1'b1; i_addr_inc = 1'b0;
    i_wr_valid = 1'b0; i_wr_data = '0;

    // Reset state
    step();
    step();
    chk("rst_we_n", o_sram_we_n, 1'b1);
    chk("rst_oe_n", o_sram_oe_n, 1'b1);
    chk("rst_ce_n", o_sram_ce_n, 1'b1);
    chk("rst_ub_n", o_sram_ub_n, 1'b1);
    chk("rst_lb_n", o_sram_lb_n, 1'b1);
    chk("rst_dq_oe", o_dq_oe, 1'b0);
    chk("rst_rd_valid", o_rd_valid, 1'b0);
    chk("rst_frame_done", o_frame_done, 1'b0);
    chk("rst_dq_out", o_dq_out, 0);
    chk("rst_rd_data", o_rd_data, 0);
    chk("rst_addr", o_sram_addr, 0);
    chk("rst_ready", o_wr_ready, 1'b0);
    @(negedge i_clk) rst_n = 1'b1;
    step();
    chk("idle_ce_n", o_sram_ce_n, 1'b1);

    // Scenario 1: full frame 0x0001..0x0008, valid held high
    write_stream(NM, 1'b0);
    end_frame();
    cmp_writes();
    chk("s1_frame_done_cnt", fd_cnt, exp_fd);

    // Scenario 2: ten reads, wrapping inside READ
    read_stream(10, 1'b0);

    // Scenarios 3+4: both requests together, then close window mid-strobe
    i_WE_n = 1'b0; i_OE_n = 1'b0; i_wr_valid = 1'b0;
    step();
    chk("s3_left_idle", o_sram_ce_n, 1'b0);
    chk("s3_write_ready", o_wr_ready, 1'b1);
    chk("s3_oe_n_high", o_sram_oe_n, 1'b1);
    chk("s3_dq_oe", o_dq_oe, 1'b1);
    write_stream(3, 1'b0);
    chk("s4_strobe_low", o_sram_we_n, 1'b0);
    chk("s4_strobe_addr", o_sram_addr, 2);
    chk("s3_oe_n_still_high", o_sram_oe_n, 1'b1);
    i_WE_n = 1'b1; i_OE_n = 1'b1;
    step();
    chk("s4_addr_after", o_sram_addr, 3);
    chk("s4_we_n_released", o_sram_we_n, 1'b1);
    chk("s4_turn_dq_oe", o_dq_oe, 1'b0);
    chk("s4_turn_ce_n", o_sram_ce_n, 1'b0);
    i_wr_valid = 1'b0;
    step();
    step();
    chk("s4_idle", o_sram_ce_n, 1'b1);
    cmp_writes();

    // Scenario 5: reset while strobing address 1
    saved = ref_mem[1];
    write_stream(2, 1'b0);
    chk("s5_strobe_low", o_sram_we_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_we_n_async", o_sram_we_n, 1'b1);
    chk("s5_dq_oe_async", o_dq_oe, 1'b0);
    chk("s5_ce_n_async", o_sram_ce_n, 1'b1);
    i_WE_n = 1'b1; i_wr_valid = 1'b0;
    void'(exp_w_addr.pop_back());
    void'(exp_w_data.pop_back());
    ref_mem[1] = saved;
    @(negedge i_clk) rst_n = 1'b1;
    step();
    chk("s5_addr_zero", o_sram_addr, 0);
    chk("s5_idle", o_sram_ce_n, 1'b1);
    cmp_writes();

    // Scenario 6: direct write-to-read switch with random data
    write_stream(2, 1'b1);
    i_WE_n = 1'b1; i_wr_valid = 1'b0;
    read_stream(5, 1'b1);
    cmp_writes();

    // Random frame with gapped valid, then gapped reads past the wrap
    write_stream(NM, 1'b1);
    end_frame();
    cmp_writes();
    read_stream(12, 1'b1);

    chk("frame_done_total", fd_cnt, exp_fd);
    chk("dq_oe_with_oe_n", overlap_cnt, 0);
    chk("oe_fall_after_drive", oe_fall_bad, 0);
    chk("we_pulse_width", we_double, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
